// File: rtl/galaksija_autotype.sv
// ASCII-to-keystroke injector: turns accepted bytes into timed press/release events on the
// 11-bit ps2_key bus, wrapping lowercase letters in a Shift press/release pair.
module galaksija_autotype #(
  parameter int unsigned HOLD_CYCLES = 200000,
  parameter int unsigned GAP_CYCLES  = 400000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic        abort,
  output logic [10:0] ps2_key,
  output logic        busy,
  output logic        bad_char
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShDn,
    StKeyDn,
    StKeyUp,
    StGap
  } state_e;

  localparam logic [CNT_W-1:0] HoldLoad  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLoad   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [7:0]       ShiftCode = 8'h12;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       code_q, code_d;
  logic             shift_q, shift_d;
  logic             key_dn_q, key_dn_d;
  logic             shift_dn_q, shift_dn_d;
  logic             abort_pend_q, abort_pend_d;
  logic [10:0]      ps2_q, ps2_d;
  logic             bad_q, bad_d;
  logic [9:0]       map;

  // Returns {mapped, shift, scancode}; lowercase letters reuse the uppercase code.
  function automatic logic [9:0] map_char(input logic [7:0] c);
    logic [7:0] u;
    logic [7:0] code;
    logic       ok;
    logic       sh;
    sh   = (c >= 8'h61) && (c <= 8'h7a);
    u    = sh ? (c - 8'h20) : c;
    ok   = 1'b1;
    code = 8'h00;
    case (u)
      8'h41: code = 8'h1c;  8'h42: code = 8'h32;  8'h43: code = 8'h21;
      8'h44: code = 8'h23;  8'h45: code = 8'h24;  8'h46: code = 8'h2b;
      8'h47: code = 8'h34;  8'h48: code = 8'h33;  8'h49: code = 8'h43;
      8'h4a: code = 8'h3b;  8'h4b: code = 8'h42;  8'h4c: code = 8'h4b;
      8'h4d: code = 8'h3a;  8'h4e: code = 8'h31;  8'h4f: code = 8'h44;
      8'h50: code = 8'h4d;  8'h51: code = 8'h15;  8'h52: code = 8'h2d;
      8'h53: code = 8'h1b;  8'h54: code = 8'h2c;  8'h55: code = 8'h3c;
      8'h56: code = 8'h2a;  8'h57: code = 8'h1d;  8'h58: code = 8'h22;
      8'h59: code = 8'h35;  8'h5a: code = 8'h1a;
      8'h30: code = 8'h45;  8'h31: code = 8'h16;  8'h32: code = 8'h1e;
      8'h33: code = 8'h26;  8'h34: code = 8'h25;  8'h35: code = 8'h2e;
      8'h36: code = 8'h36;  8'h37: code = 8'h3d;  8'h38: code = 8'h3e;
      8'h39: code = 8'h46;
      8'h20: code = 8'h29;  8'h0d: code = 8'h5a;  8'h08: code = 8'h66;
      8'h1b: code = 8'h76;  8'h3b: code = 8'h4c;  8'h3a: code = 8'h7c;
      8'h2c: code = 8'h41;  8'h3d: code = 8'h55;  8'h2e: code = 8'h49;
      8'h2f: code = 8'h4a;
      default: ok = 1'b0;
    endcase
    return {ok, sh & ok, code};
  endfunction

  // New event: flip the toggle bit so the consumer sees a change even for repeated codes.
  function automatic logic [10:0] emit(input logic [10:0] prev, input logic pr,
                                       input logic [7:0] code);
    return {~prev[10], pr, 1'b0, code};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      code_q       <= 8'h00;
      shift_q      <= 1'b0;
      key_dn_q     <= 1'b0;
      shift_dn_q   <= 1'b0;
      abort_pend_q <= 1'b0;
      ps2_q        <= 11'h000;
      bad_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      code_q       <= code_d;
      shift_q      <= shift_d;
      key_dn_q     <= key_dn_d;
      shift_dn_q   <= shift_dn_d;
      abort_pend_q <= abort_pend_d;
      ps2_q        <= ps2_d;
      bad_q        <= bad_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = (timer_q != '0) ? (timer_q - CNT_W'(1)) : '0;
    code_d       = code_q;
    shift_d      = shift_q;
    key_dn_d     = key_dn_q;
    shift_dn_d   = shift_dn_q;
    abort_pend_d = abort_pend_q;
    ps2_d        = ps2_q;
    bad_d        = 1'b0;
    map          = map_char(char_in);
    unique case (state_q)
      StIdle: begin
        if (char_valid) begin
          if (map[9]) begin
            code_d       = map[7:0];
            shift_d      = map[8];
            abort_pend_d = abort;
            state_d      = StLoad;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      StLoad: begin
        abort_pend_d = 1'b0;
        if (abort || abort_pend_q) begin
          state_d = StGap;
          timer_d = GapLoad;
        end else if (shift_q) begin
          ps2_d      = emit(ps2_q, 1'b1, ShiftCode);
          shift_dn_d = 1'b1;
          state_d    = StShDn;
          timer_d    = HoldLoad;
        end else begin
          ps2_d    = emit(ps2_q, 1'b1, code_q);
          key_dn_d = 1'b1;
          state_d  = StKeyDn;
          timer_d  = HoldLoad;
        end
      end
      StShDn: begin
        if (abort) begin
          ps2_d      = emit(ps2_q, 1'b0, ShiftCode);
          shift_dn_d = 1'b0;
          state_d    = StGap;
          timer_d    = GapLoad;
        end else if (timer_q == '0) begin
          ps2_d    = emit(ps2_q, 1'b1, code_q);
          key_dn_d = 1'b1;
          state_d  = StKeyDn;
          timer_d  = HoldLoad;
        end
      end
      StKeyDn: begin
        if (abort || (timer_q == '0)) begin
          ps2_d    = emit(ps2_q, 1'b0, code_q);
          key_dn_d = 1'b0;
          if (shift_dn_q) begin
            state_d = StKeyUp;
            timer_d = HoldLoad;
          end else begin
            state_d = StGap;
            timer_d = GapLoad;
          end
        end
      end
      // Already on the release path; abort here changes nothing.
      StKeyUp: begin
        if (timer_q == '0) begin
          ps2_d      = emit(ps2_q, 1'b0, ShiftCode);
          shift_dn_d = 1'b0;
          state_d    = StGap;
          timer_d    = GapLoad;
        end
      end
      StGap: begin
        if (timer_q == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    char_ready = (state_q == StIdle) && reset;
    busy       = (state_q != StIdle);
    ps2_key    = ps2_q;
    bad_char   = bad_q;
  end

endmodule

// File: tb/tb_galaksija_autotype.sv
// Directed bench for galaksija_autotype with small HOLD/GAP values and an event log of ps2_key.
module tb_galaksija_autotype;

  localparam int H = 4;
  localparam int G = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic        abort = 1'b0;
  logic [10:0] ps2_key;
  logic        busy;
  logic        bad_char;

  galaksija_autotype #(
    .HOLD_CYCLES(H),
    .GAP_CYCLES (G),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .char_in   (char_in),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .abort     (abort),
    .ps2_key   (ps2_key),
    .busy      (busy),
    .bad_char  (bad_char)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [10:0] key;
  } ev_t;

  ev_t         log_q[$];
  logic [10:0] last_key = 11'h000;

  always @(posedge clk) begin
    #1;
    if (ps2_key !== last_key) begin
      log_q.push_back('{at: cyc, key: ps2_key});
      last_key = ps2_key;
    end
  end

  int checks = 0;
  int errors = 0;
  int rd = 0;
  bit tog = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_ev(input string name, input int at, input bit pr, input logic [7:0] code);
    logic [10:0] e;
    tog = ~tog;
    e   = {tog, pr, 1'b0, code};
    if (rd >= log_q.size()) begin
      chk({name, " event count"}, log_q.size(), rd + 1);
    end else begin
      chk({name, " key"}, log_q[rd].key, e);
      chk({name, " edge"}, log_q[rd].at, at);
      rd++;
    end
  endtask

  task automatic exp_char(input string name, input int acc, input logic [7:0] code, input bit sh);
    if (sh) begin
      exp_ev({name, " shift dn"}, acc + 1, 1'b1, 8'h12);
      exp_ev({name, " key dn"}, acc + 1 + H, 1'b1, code);
      exp_ev({name, " key up"}, acc + 1 + 2 * H, 1'b0, code);
      exp_ev({name, " shift up"}, acc + 1 + 3 * H, 1'b0, 8'h12);
    end else begin
      exp_ev({name, " key dn"}, acc + 1, 1'b1, code);
      exp_ev({name, " key up"}, acc + 1 + H, 1'b0, code);
    end
  endtask

  task automatic send(input logic [7:0] c, input bit ab, output int acc, output logic bc,
                      output logic bz);
    int n = 0;
    @(negedge clk);
    while (!char_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready before send", char_ready, 1);
    char_in    = c;
    char_valid = 1'b1;
    abort      = ab;
    @(posedge clk);
    #1;
    acc        = cyc;
    bc         = bad_char;
    bz         = busy;
    char_valid = 1'b0;
    abort      = 1'b0;
  endtask

  task automatic wait_ready(output int rc);
    int n = 0;
    while (!char_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    rc = cyc;
  endtask

  typedef struct {
    logic [7:0] ch;
    logic [7:0] code;
    bit         sh;
    bit         bad;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          acc;
    int          rc;
    int          accs[4];
    logic        bc;
    logic        bz;
    logic [7:0]  s[4];
    logic [7:0]  sc[4];
    bit          ssh[4];
    int          i;
    int          guard;
    bit          r;

    vecs[0]  = '{8'h41, 8'h1c, 1'b0, 1'b0};  // 'A'
    vecs[1]  = '{8'h61, 8'h1c, 1'b1, 1'b0};  // 'a'
    vecs[2]  = '{8'h7e, 8'h00, 1'b0, 1'b1};  // '~'
    vecs[3]  = '{8'h31, 8'h16, 1'b0, 1'b0};  // '1'
    vecs[4]  = '{8'h0d, 8'h5a, 1'b0, 1'b0};  // CR
    vecs[5]  = '{8'h7a, 8'h1a, 1'b1, 1'b0};  // 'z'
    vecs[6]  = '{8'h3b, 8'h4c, 1'b0, 1'b0};  // ';'
    vecs[7]  = '{8'h39, 8'h46, 1'b0, 1'b0};  // '9'
    vecs[8]  = '{8'h20, 8'h29, 1'b0, 1'b0};  // space
    vecs[9]  = '{8'h1b, 8'h76, 1'b0, 1'b0};  // ESC
    vecs[10] = '{8'h40, 8'h00, 1'b0, 1'b1};  // '@'
    vecs[11] = '{8'h4d, 8'h3a, 1'b0, 1'b0};  // 'M'

    #2;
    chk("reset ps2_key", ps2_key, 0);
    chk("reset char_ready", char_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset bad_char", bad_char, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    chk("ready after reset", char_ready, 1);

    for (int k = 0; k < 12; k++) begin
      send(vecs[k].ch, 1'b0, acc, bc, bz);
      chk($sformatf("vec%0d bad_char", k), bc, vecs[k].bad);
      chk($sformatf("vec%0d busy", k), bz, !vecs[k].bad);
      if (vecs[k].bad) begin
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d bad_char pulse end", k), bad_char, 0);
        wait_ready(rc);
        chk($sformatf("vec%0d ready", k), rc, acc + 1);
      end else begin
        wait_ready(rc);
        chk($sformatf("vec%0d ready edge", k), rc,
            acc + 1 + (vecs[k].sh ? 3 * H : H) + G);
        exp_char($sformatf("vec%0d", k), acc, vecs[k].code, vecs[k].sh);
      end
      chk($sformatf("vec%0d no extra events", k), log_q.size(), rd);
    end

    // Stream "Ab1\r" with char_valid held high throughout.
    s   = '{8'h41, 8'h62, 8'h31, 8'h0d};
    sc  = '{8'h1c, 8'h32, 8'h16, 8'h5a};
    ssh = '{1'b0, 1'b1, 1'b0, 1'b0};
    i = 0;
    guard = 0;
    char_in    = s[0];
    char_valid = 1'b1;
    while (i < 4 && guard < 400) begin
      @(negedge clk);
      r = char_ready;
      @(posedge clk);
      #1;
      if (r) begin
        accs[i] = cyc;
        i++;
        if (i < 4) char_in = s[i];
        else char_valid = 1'b0;
      end
      guard++;
    end
    char_valid = 1'b0;
    chk("stream accepts", i, 4);
    wait_ready(rc);
    chk("stream A->b spacing", accs[1] - accs[0], 2 + H + G);
    chk("stream b->1 spacing", accs[2] - accs[1], 2 + 3 * H + G);
    chk("stream 1->CR spacing", accs[3] - accs[2], 2 + H + G);
    for (int k = 0; k < 4; k++) exp_char($sformatf("stream%0d", k), accs[k], sc[k], ssh[k]);
    chk("stream no extra events", log_q.size(), rd);

    // 'b' aborted one cycle after the key press.
    send(8'h62, 1'b0, acc, bc, bz);
    while (cyc < acc + 1 + H) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    wait_ready(rc);
    chk("abort ready edge", rc, acc + 6 + H + G);
    exp_ev("abort shift dn", acc + 1, 1'b1, 8'h12);
    exp_ev("abort key dn", acc + 1 + H, 1'b1, 8'h32);
    exp_ev("abort key up", acc + 2 + H, 1'b0, 8'h32);
    exp_ev("abort shift up", acc + 2 + 2 * H, 1'b0, 8'h12);
    chk("abort no extra events", log_q.size(), rd);

    // Abort on the accepting edge: character taken, nothing emitted.
    send(8'h63, 1'b1, acc, bc, bz);
    chk("abort-at-accept busy", bz, 1);
    wait_ready(rc);
    chk("abort-at-accept ready edge", rc, acc + 1 + G);
    chk("abort-at-accept no events", log_q.size(), rd);

    // Reset during the KEY_DN hold.
    send(8'h4b, 1'b0, acc, bc, bz);
    while (cyc < acc + 2) begin
      @(posedge clk);
      #1;
    end
    exp_ev("reset-mid key dn", acc + 1, 1'b1, 8'h42);
    reset = 1'b0;
    #1;
    chk("mid reset ps2_key", ps2_key, 0);
    chk("mid reset char_ready", char_ready, 0);
    chk("mid reset busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post reset char_ready", char_ready, 1);
    chk("post reset busy", busy, 0);
    @(negedge clk);
    log_q.delete();
    rd  = 0;
    tog = 1'b0;

    send(8'h41, 1'b0, acc, bc, bz);
    wait_ready(rc);
    chk("post reset A ready edge", rc, acc + 1 + H + G);
    exp_char("post reset A", acc, 8'h1c, 1'b0);
    chk("post reset no extra events", log_q.size(), rd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
